// File: rtl/rmii_rx_framer.sv
// rmii_rx_framer: RMII receive framer.
// Hunts preamble/SFD and assembles LSB-first dibits into bytes.
// Stores each frame in a byte buffer and extracts a header field.
// Holds each completed frame under a valid/ack handshake.
// Counts frames that arrive while a frame is held, then drops them.
// Optional feature: define RMII_RX_CRC_EN to check the CRC-32 FCS.
// Without RMII_RX_CRC_EN, crc_ok reports 1 for every frame.
module rmii_rx_framer #(
  parameter int unsigned BUF_DEPTH   = 128,
  parameter int unsigned FIELD_OFS   = 14,
  parameter int unsigned FIELD_BYTES = 4,
  localparam int unsigned AW         = $clog2(BUF_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 rxd,
  input  logic                       crs_dv,
  input  logic                       rx_er,
  output logic                       frame_valid,
  input  logic                       frame_ack,
  output logic [15:0]                frame_len,
  output logic [8*FIELD_BYTES-1:0]   field_data,
  output logic                       crc_ok,
  output logic                       overflow,
  output logic                       rx_err,
  output logic                       runt,
  output logic [7:0]                 drop_cnt,
  input  logic [AW-1:0]              rd_addr,
  output logic [7:0]                 rd_data
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_HOLD, S_DROP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  phase;
  logic [5:0]  sr;
  logic [15:0] len;
  logic [1:0]  quiet;
  logic [7:0]  mem [BUF_DEPTH];

  logic        start_c, end_c, dibit_c, byte_done_c, drop_hit_c;
  logic        in_buf_c, crc_match_c;
  logic [7:0]  byte_c;

  assign byte_c   = {rxd, sr};
  assign in_buf_c = (len < 16'(BUF_DEPTH));

`ifdef RMII_RX_CRC_EN
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  logic [31:0] crc;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Reflected CRC-32 over every accepted dibit of the frame, FCS included
  always_ff @(posedge clk) begin
    if (rst || start_c) crc <= 32'hFFFF_FFFF;
    else if (dibit_c)   crc <= crc_step(crc, rxd);
  end

  assign crc_match_c = (crc == CRC_RESIDUE);
`else
  assign crc_match_c = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and per-cycle datapath strobes
  always_comb begin
    state_nxt   = state;
    start_c     = 1'b0;
    end_c       = 1'b0;
    dibit_c     = 1'b0;
    byte_done_c = 1'b0;
    drop_hit_c  = 1'b0;
    case (state)
      S_IDLE: if (crs_dv && rxd == 2'b01) state_nxt = S_PRE;
      S_PRE: begin
        if (!crs_dv)              state_nxt = S_IDLE;
        else if (rxd == 2'b11) begin
          state_nxt = S_DATA;
          start_c   = 1'b1;
        end
        else if (rxd != 2'b01)    state_nxt = S_IDLE;
      end
      S_DATA: begin
        if (phase == 2'd0 && !crs_dv) begin
          state_nxt = S_HOLD;
          end_c     = 1'b1;
        end else begin
          dibit_c     = 1'b1;
          byte_done_c = (phase == 2'd3);
        end
      end
      S_HOLD: begin
        if (frame_ack)                      state_nxt = crs_dv ? S_DROP : S_IDLE;
        else if (crs_dv && quiet == 2'd2)   drop_hit_c = 1'b1;
      end
      S_DROP: if (!crs_dv && quiet != 2'd0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Consecutive carrier-low cycles, saturating at 2; arms drop counting
  always_ff @(posedge clk) begin
    if (rst || crs_dv)       quiet <= 2'd0;
    else if (quiet != 2'd2)  quiet <= quiet + 2'd1;
  end

  // Byte assembly, length, field capture and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= 2'd0;
      sr          <= 6'd0;
      len         <= 16'd0;
      field_data  <= '0;
      overflow    <= 1'b0;
      rx_err      <= 1'b0;
      crc_ok      <= 1'b0;
      runt        <= 1'b0;
      frame_len   <= 16'd0;
      drop_cnt    <= 8'd0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= (state_nxt == S_HOLD);
      if (start_c) begin
        phase      <= 2'd0;
        len        <= 16'd0;
        field_data <= '0;
        overflow   <= 1'b0;
        rx_err     <= 1'b0;
        crc_ok     <= 1'b0;
        runt       <= 1'b0;
      end
      if (state == S_DATA && rx_er) rx_err <= 1'b1;
      if (dibit_c) begin
        phase <= phase + 2'd1;
        case (phase)
          2'd0:    sr[1:0] <= rxd;
          2'd1:    sr[3:2] <= rxd;
          2'd2:    sr[5:4] <= rxd;
          default: sr      <= sr;
        endcase
      end
      if (byte_done_c) begin
        if (!in_buf_c)       overflow <= 1'b1;
        if (len != 16'hFFFF) len      <= len + 16'd1;
        for (int k = 0; k < int'(FIELD_BYTES); k++) begin
          if (len == 16'(FIELD_OFS + 32'(k)))
            field_data[8*(int'(FIELD_BYTES)-1-k) +: 8] <= byte_c;
        end
      end
      if (end_c) begin
        frame_len <= len;
        runt      <= (len < 16'd64);
        crc_ok    <= crc_match_c;
      end
      if (drop_hit_c && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Frame buffer write port
  always_ff @(posedge clk) begin
    if (byte_done_c && in_buf_c) mem[len[AW-1:0]] <= byte_c;
  end

  // Registered buffer read port
  always_ff @(posedge clk) begin
    if (rst) rd_data <= 8'd0;
    else     rd_data <= mem[rd_addr];
  end

endmodule
